// File: rtl/stopwatch_timebase.sv
// Stopwatch front end: 100 Hz prescaler, start/pause/clear FSM and sub-minute BCD digit chain.
// Define STOPWATCH_LAP_EN to build the lap-freeze display register driven by btn_lap.
module stopwatch_timebase #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [3:0] centesimas,
  output logic [3:0] decimas,
  output logic [3:0] unidadesSegundo,
  output logic [2:0] decenasSegundo,
  output logic       stay,
  output logic       min_carry,
  output logic       running
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  // state | meaning
  // IDLE  | cleared, digits and prescaler held at zero
  // RUN   | prescaler counting, digits advance on stay
  // PAUSE | prescaler and digits frozen; start resumes, clear returns to IDLE
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [3:0]    cent;
  logic [3:0]    dec;
  logic [3:0]    uni;
  logic [2:0]    tens;
  logic [14:0]   live;

  // [0],[1] synchroniser, [2] history; press is registered once more
  logic [2:0] start_sync;
  logic [2:0] clear_sync;
  logic       start_press;
  logic       clear_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_sync  <= '0;
      clear_sync  <= '0;
      start_press <= 1'b0;
      clear_press <= 1'b0;
    end else begin
      start_sync  <= {start_sync[1:0], btn_start};
      clear_sync  <= {clear_sync[1:0], btn_clear};
      start_press <= start_sync[1] & ~start_sync[2];
      clear_press <= clear_sync[1] & ~clear_sync[2];
    end
  end

  assign stay      = (state == RUN) && (presc == PRESC_MAX);
  assign min_carry = stay && (tens == 3'd5) && (uni == 4'd9) && (dec == 4'd9) && (cent == 4'd9);
  assign live      = {tens, uni, dec, cent};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      presc   <= '0;
      cent    <= 4'd0;
      dec     <= 4'd0;
      uni     <= 4'd0;
      tens    <= 3'd0;
    end else begin
      if (state == RUN)
        presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);

      if (stay) begin
        cent <= (cent >= 4'd9) ? 4'd0 : cent + 4'd1;
        if (cent == 4'd9)
          dec <= (dec >= 4'd9) ? 4'd0 : dec + 4'd1;
        if ((cent == 4'd9) && (dec == 4'd9))
          uni <= (uni >= 4'd9) ? 4'd0 : uni + 4'd1;
        if ((cent == 4'd9) && (dec == 4'd9) && (uni == 4'd9))
          tens <= (tens >= 3'd5) ? 3'd0 : tens + 3'd1;
      end

      case (state)
        IDLE: begin
          if (start_press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (start_press) begin
            state   <= PAUSE;
            running <= 1'b0;
          end
        end
        PAUSE: begin
          // clear has priority over a simultaneous start while paused
          if (clear_press) begin
            state   <= IDLE;
            running <= 1'b0;
            presc   <= '0;
            cent    <= 4'd0;
            dec     <= 4'd0;
            uni     <= 4'd0;
            tens    <= 3'd0;
          end else if (start_press) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [2:0]  lap_sync;
  logic        lap_press;
  logic        frozen;
  logic [14:0] disp;

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_sync  <= '0;
      lap_press <= 1'b0;
      frozen    <= 1'b0;
      disp      <= '0;
    end else begin
      lap_sync  <= {lap_sync[1:0], btn_lap};
      lap_press <= lap_sync[1] & ~lap_sync[2];
      if (start_press || clear_press) begin
        frozen <= 1'b0;
      end else if (lap_press) begin
        if (frozen) begin
          frozen <= 1'b0;
        end else if (state == RUN) begin
          frozen <= 1'b1;
          disp   <= live;
        end
      end
    end
  end

  assign {decenasSegundo, unidadesSegundo, decimas, centesimas} = frozen ? disp : live;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign {decenasSegundo, unidadesSegundo, decimas, centesimas} = live;
`endif

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Self-checking bench for stopwatch_timebase: directed scenarios plus random button traffic
// compared every cycle against a centisecond-count reference model.
module tb_stopwatch_timebase;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, btn_start, btn_clear, btn_lap;
  logic [3:0] centesimas, decimas, unidadesSegundo;
  logic [2:0] decenasSegundo;
  logic stay, min_carry, running;
  logic [14:0] dig;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stopwatch_timebase #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .centesimas(centesimas), .decimas(decimas),
    .unidadesSegundo(unidadesSegundo), .decenasSegundo(decenasSegundo),
    .stay(stay), .min_carry(min_carry), .running(running)
  );

  assign dig = {decenasSegundo, unidadesSegundo, decimas, centesimas};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: elapsed time as an integer number of centiseconds modulo one minute.
  typedef struct packed {
    logic [1:0] mode;     // 0 idle, 1 run, 2 pause
    int         presc;
    int         count;
    logic       frozen;
    int         fcount;
    logic [3:0] hs;       // bit k = button level sampled k+1 edges ago
    logic [3:0] hc;
    logic [3:0] hl;
  } model_t;

  model_t m = '0;

  function automatic model_t step(model_t cur, logic r, logic bs, logic bc, logic bl);
    model_t nx = cur;
    logic sp, cp, lp, tk;
    if (r) return '0;
    // a level sampled three edges earlier after a low sample acts on this edge
    sp = cur.hs[2] && !cur.hs[3];
    cp = cur.hc[2] && !cur.hc[3];
    lp = LAP && cur.hl[2] && !cur.hl[3];
    tk = (cur.mode == 2'd1) && (cur.presc == DIV - 1);
    if (sp || cp) nx.frozen = 1'b0;
    else if (lp) begin
      if (cur.frozen) nx.frozen = 1'b0;
      else if (cur.mode == 2'd1) begin
        nx.frozen = 1'b1;
        nx.fcount = cur.count;
      end
    end
    if (tk) nx.count = (cur.count + 1) % 6000;
    if (cur.mode == 2'd1) nx.presc = (cur.presc + 1) % DIV;
    case (cur.mode)
      2'd0: if (sp) nx.mode = 2'd1;
      2'd1: if (sp) nx.mode = 2'd2;
      default: begin
        if (cp) begin
          nx.mode  = 2'd0;
          nx.count = 0;
          nx.presc = 0;
        end else if (sp) nx.mode = 2'd1;
      end
    endcase
    nx.hs = {cur.hs[2:0], bs};
    nx.hc = {cur.hc[2:0], bc};
    nx.hl = {cur.hl[2:0], bl};
    return nx;
  endfunction

  function automatic logic [31:0] bcd(int c);
    return ((c / 1000) << 12) | (((c / 100) % 10) << 8) | (((c / 10) % 10) << 4) | (c % 10);
  endfunction

  always @(posedge clk) m <= step(m, rst, btn_start, btn_clear, btn_lap);

  always @(negedge clk) begin
    logic es;
    es = (m.mode == 2'd1) && (m.presc == DIV - 1);
    check("digits", dig, bcd((LAP && m.frozen) ? m.fcount : m.count));
    check("stay", stay, es);
    check("min_carry", min_carry, es && (m.count == 5999));
    check("running", running, m.mode == 2'd1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_dig(input logic [14:0] tgt, input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && dig !== tgt; i++) tick();
    check(tag, dig, tgt);
  endtask

  task automatic wait_stay(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc && stay !== 1'b1; i++) tick();
    check(tag, stay, 1);
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    repeat (5) tick();
    btn_start = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int ns, gap, last;
    logic [14:0] prev;
    rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
    tick(); tick();
    check("rst_digits", dig, 0);
    check("rst_running", running, 0);
    check("rst_stay", stay, 0);
    check("rst_carry", min_carry, 0);
    rst = 1'b0;
    ns = 0;
    repeat (100) begin tick(); ns += stay; end
    check("idle_no_stay", ns, 0);

    btn_start = 1'b1;
    tick(); tick(); tick();
    check("start_lat_early", running, 0);
    tick();
    check("start_lat", running, 1);
    btn_start = 1'b0;

    ns = 0; last = 0;
    for (int i = 1; i <= 400 && ns < 25; i++) begin
      tick();
      if (stay) begin
        ns++;
        if (ns >= 2 && ns <= 4) check("stay_period", i - last, DIV);
        last = i;
      end
    end
    check("stay_count", ns, 25);
    tick();
    check("digits_25", dig, 15'h0025);

    wait_dig(15'h5999, 70000, "reach_5999");
    wait_stay(20, "stay_at_5999");
    check("carry_high", min_carry, 1);
    tick();
    check("rollover", dig, 0);
    check("carry_one_clk", min_carry, 0);

    // pause lands on presc 4: press sampled after presc 0 acts three edges later
    for (int i = 0; i < 20 && m.presc != 0; i++) tick();
    btn_start = 1'b1;
    repeat (5) tick();
    btn_start = 1'b0;
    check("paused", running, 0);
    repeat (50) tick();
    btn_start = 1'b1;
    for (int i = 0; i < 8 && running !== 1'b1; i++) tick();
    check("resumed", running, 1);
    btn_start = 1'b0;
    prev = dig; gap = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (dig !== prev) begin gap = i; break; end
    end
    check("resume_gap", gap, 6);

    btn_clear = 1'b1;
    repeat (6) tick();
    btn_clear = 1'b0;
    check("clear_in_run", running, 1);

    press_start();
    check("pause2", running, 0);
    btn_start = 1'b1; btn_clear = 1'b1;
    repeat (5) tick();
    btn_start = 1'b0; btn_clear = 1'b0;
    check("sc_pause_running", running, 0);
    check("sc_pause_digits", dig, 0);
    repeat (3) tick();
    btn_start = 1'b1; btn_clear = 1'b1;
    repeat (5) tick();
    btn_start = 1'b0; btn_clear = 1'b0;
    check("sc_idle_running", running, 1);

`ifdef STOPWATCH_LAP_EN
    press_start();
    btn_clear = 1'b1;
    repeat (5) tick();
    btn_clear = 1'b0;
    repeat (3) tick();
    press_start();
    wait_dig(15'h1234, 14000, "reach_1234");
    btn_lap = 1'b1;
    repeat (5) tick();
    btn_lap = 1'b0;
    check("lap_frozen", dig, 15'h1234);
    ns = 0;
    repeat (40) begin tick(); ns += stay; end
    check("lap_hold", dig, 15'h1234);
    check("lap_stay_continues", ns >= 3, 1);
    btn_lap = 1'b1;
    repeat (5) tick();
    btn_lap = 1'b0;
    check("lap_release", dig != 15'h1234, 1);
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 11) == 0) btn_clear = ~btn_clear;
      if ($urandom_range(0, 9) == 0) btn_lap = ~btn_lap;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
